axi4_stream_serializer: RTL and testbench
=========================================

# axi4_stream_serializer

Width-down converter for AXI4-Stream traffic. It accepts one wide word of `WIDTH*RATIO` bits and emits it as `RATIO` narrow beats, least-significant slice first, flagging the final beat with `m_axis_tlast`. It sits downstream of the wide-datapath stream FIFOs and drives narrow-width consumers. It runs at full throughput: there are no bubbles between consecutive wide words.

## Interface
Parameters:
- `WIDTH`, 8: bit width of one output beat.
- `RATIO`, 4: output beats per input word. Must be ≥ 1; a power of two is not required.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `s_axis_tdata`, in, `WIDTH*RATIO`: wide input word.
- `s_axis_tvalid`, in, 1: input word valid.
- `s_axis_tready`, out, 1: block can accept a word this cycle.
- `m_axis_tdata`, out, `WIDTH`: current narrow beat.
- `m_axis_tvalid`, out, 1: narrow beat valid.
- `m_axis_tready`, in, 1: downstream accepts the beat.
- `m_axis_tlast`, out, 1: high on the beat carrying the most-significant slice.
- `word_count`, out, 16: number of fully emitted wide words; wraps.

## Operation
- Internal state: wide shift register `sreg`, beat counter `beat_idx` of width max(1, $clog2(RATIO)), and two-state FSM.
  - IDLE: no beat held. `m_axis_tvalid` = 0.
  - SEND: a beat is presented.
- Input handshake: `s_hs = s_axis_tvalid && s_axis_tready`.
- Output handshake: `m_hs = m_axis_tvalid && m_axis_tready`.
- `last_beat = (beat_idx == RATIO-1)`.
- `s_axis_tready` is combinational and equals `!reset && (state==IDLE || (m_hs && last_beat))`.
- IDLE with `s_hs`:
  - load `sreg` with the word;
  - `m_axis_tdata` ← slice [WIDTH-1:0];
  - `beat_idx` ← 0;
  - go to SEND.
- SEND with `m_hs` and not `last_beat`:
  - shift `sreg` right by WIDTH;
  - present the next slice;
  - `beat_idx` increments.
- SEND with `m_hs && last_beat`:
  - `word_count` increments, modulo 2^16.
  - If `s_hs` in the same cycle: load the new word, beat 0 follows with no gap, stay in SEND.
  - Otherwise: go to IDLE and drive `m_axis_tvalid` low.
- SEND without `m_hs`: `m_axis_tdata`, `m_axis_tlast` and `beat_idx` hold. This is the AXI stability rule.
- `m_axis_tlast` is registered and equals `last_beat` for the presented beat.
- `RATIO == 1`: each word becomes one beat with `m_axis_tlast` = 1, giving a registered pass-through.
- Input data is never modified; slice k = `s_axis_tdata[k*WIDTH +: WIDTH]`.

## Timing
- Reset values, applied immediately on `reset` assertion:
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `m_axis_tlast` = 0, `word_count` = 0;
  - FSM = IDLE, `beat_idx` = 0;
  - `s_axis_tready` = 0 while `reset` is high, and 1 in the first cycle after release.
- Latency: a word accepted at edge N has beat 0 valid after edge N. With `m_axis_tready` held high, the last beat is valid after edge N+RATIO-1.
- Throughput: one narrow beat per cycle sustained, with no idle cycle between words.
- `s_axis_tready` depends combinationally on `m_axis_tready`. This path is accepted; insert a FIFO upstream if timing requires.
- Reset mid-word: remaining beats are dropped. `word_count` does not count the partial word.
- `word_count` wraps from 0xFFFF to 0x0000 with no flag.

## Structure
- Shared package `axi4_stream_pkg`:
  - `typedef enum logic {IDLE, SEND} ser_state_t`;
  - localparam `WORD_COUNT_WIDTH = 16`.
- Counter width is computed locally from `RATIO`.
- Single module; no sub-module. Output registers, shift register and FSM share one `always_ff` with asynchronous reset.

## Test plan
Parameters for all scenarios: WIDTH=8, RATIO=4.
- Reset: assert `reset` mid-simulation → all outputs 0 and `s_axis_tready`=0 at once; after release, `s_axis_tready`=1 on the next cycle.
- Single word: 0xDDCCBBAA with `m_axis_tready`=1 → beats AA, BB, CC, DD on 4 consecutive cycles; `tlast` only with DD; `word_count`=1.
- Back-to-back: words 0x04030201 then 0x08070605, both sources always ready/valid → 8 consecutive beats 01..08 with no bubble; `s_axis_tready` high in the cycle beat 04 handshakes.
- Backpressure: drop `m_axis_tready` for 3 cycles while BB is presented → `tdata`=BB, `tvalid`=1 and `s_axis_tready`=0 are held; sequence then resumes CC, DD.
- Mid-word reset: pulse `reset` after beat BB handshakes → `tvalid`=0 immediately, CC and DD never appear, `word_count`=0; the next word 0x44332211 emits 11..44 correctly.
- Counter wrap: stream 65536 words → `word_count` returns to 0x0000; word 65537 gives 0x0001.

Source files
------------

// File: rtl/axi4_stream_pkg.sv
// Shared definitions for the AXI4-Stream width converters.
package axi4_stream_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  localparam int WORD_COUNT_WIDTH = 16;

endpackage

// File: rtl/axi4_stream_serializer_if.sv
// Stream bundle for the serializer: wide slave side in, narrow master side out.
interface axi4_stream_serializer_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);
  logic [WIDTH*RATIO-1:0] s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic [WIDTH-1:0]       m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;

  // Serializer view.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  // Environment view: feeds wide words, consumes narrow beats.
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axi4_stream_serializer.sv
// Width-down converter: one WIDTH*RATIO word becomes RATIO narrow beats, LSB slice first,
// with tlast on the final beat and no bubble between consecutive words.
module axi4_stream_serializer
  import axi4_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  axi4_stream_serializer_if.slave     axis,
  output logic [WORD_COUNT_WIDTH-1:0] word_count
);

  localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DATA_W = WIDTH * RATIO;

  ser_state_t                  state_reg;
  logic [DATA_W-1:0]           sreg_reg;
  logic [IDX_W-1:0]            beat_idx_reg;
  logic [WIDTH-1:0]            tdata_reg;
  logic                        tlast_reg;
  logic [WORD_COUNT_WIDTH-1:0] word_count_reg;

  logic              s_hs;
  logic              m_hs;
  logic              last_beat;
  logic [IDX_W-1:0]  beat_idx_next;
  logic [DATA_W-1:0] sreg_shift;

  assign last_beat     = (beat_idx_reg == IDX_W'(RATIO - 1));
  assign m_hs          = (state_reg == SEND) && axis.m_axis_tready;
  assign beat_idx_next = beat_idx_reg + IDX_W'(1);
  assign sreg_shift    = sreg_reg >> WIDTH;

  // A new word is taken only when nothing is held or the final beat is leaving now.
  assign axis.s_axis_tready = !reset && ((state_reg == IDLE) || (m_hs && last_beat));
  assign s_hs               = axis.s_axis_tvalid && axis.s_axis_tready;

  assign axis.m_axis_tvalid = (state_reg == SEND);
  assign axis.m_axis_tdata  = tdata_reg;
  assign axis.m_axis_tlast  = tlast_reg;
  assign word_count         = word_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      sreg_reg       <= '0;
      beat_idx_reg   <= '0;
      tdata_reg      <= '0;
      tlast_reg      <= 1'b0;
      word_count_reg <= '0;
    end else begin
      // s_hs can only fire from IDLE or on the final-beat handshake, so loading wins.
      if (s_hs) begin
        sreg_reg     <= axis.s_axis_tdata;
        tdata_reg    <= axis.s_axis_tdata[WIDTH-1:0];
        beat_idx_reg <= '0;
        tlast_reg    <= (RATIO == 1);
        state_reg    <= SEND;
      end else if (m_hs) begin
        if (last_beat) begin
          state_reg <= IDLE;
          tlast_reg <= 1'b0;
        end else begin
          sreg_reg     <= sreg_shift;
          tdata_reg    <= sreg_shift[WIDTH-1:0];
          beat_idx_reg <= beat_idx_next;
          tlast_reg    <= (beat_idx_next == IDX_W'(RATIO - 1));
        end
      end

      if (m_hs && last_beat) begin
        word_count_reg <= word_count_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_stream_serializer.sv
// Self-checking bench: queue-based beat model checked every cycle, plus directed literal cases.
module tb_axi4_stream_serializer;

  localparam int W = 8;
  localparam int R = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst1 = 1'b1;
  logic [15:0] word_count;
  logic [15:0] word_count1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  axi4_stream_serializer_if #(.WIDTH(W), .RATIO(R)) ifc ();
  axi4_stream_serializer_if #(.WIDTH(W), .RATIO(1)) ifc1 ();

  axi4_stream_serializer #(.WIDTH(W), .RATIO(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .axis       (ifc),
    .word_count (word_count)
  );

  axi4_stream_serializer #(.WIDTH(W), .RATIO(1)) dut1 (
    .clk        (clk),
    .reset      (rst1),
    .axis       (ifc1),
    .word_count (word_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: queue of pending narrow beats ----------------
  beat_t       mq[$];
  logic [15:0] exp_wc = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_wc = '0;
    end else begin
      logic        mhs;
      logic        shs;
      logic [31:0] w;
      beat_t       b;
      mhs = (mq.size() != 0) && ifc.m_axis_tready;
      shs = ifc.s_axis_tvalid && ((mq.size() == 0) || (mq.size() == 1 && ifc.m_axis_tready));
      w   = ifc.s_axis_tdata;
      if (mhs) begin
        if (mq[0].l) exp_wc = exp_wc + 16'd1;
        void'(mq.pop_front());
      end
      if (shs) begin
        for (int k = 0; k < R; k++) begin
          b.d = w[k*W +: W];
          b.l = (k == R - 1);
          mq.push_back(b);
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_srdy;
    exp_srdy = !reset && ((mq.size() == 0) || (mq.size() == 1 && ifc.m_axis_tready));
    chk("m_tvalid", 32'(ifc.m_axis_tvalid), 32'(mq.size() != 0));
    chk("s_tready", 32'(ifc.s_axis_tready), 32'(exp_srdy));
    chk("word_count", 32'(word_count), 32'(exp_wc));
    if (mq.size() != 0) begin
      chk("m_tdata", 32'(ifc.m_axis_tdata), 32'(mq[0].d));
      chk("m_tlast", 32'(ifc.m_axis_tlast), 32'(mq[0].l));
    end
  end

  // Log of handshaked beats for the directed cases.
  logic [W-1:0] obs_d[$];
  logic         obs_l[$];
  int           obs_c[$];
  logic         obs_s[$];

  always @(posedge clk) begin
    if (!reset && ifc.m_axis_tvalid && ifc.m_axis_tready) begin
      obs_d.push_back(ifc.m_axis_tdata);
      obs_l.push_back(ifc.m_axis_tlast);
      obs_c.push_back(cyc);
      obs_s.push_back(ifc.s_axis_tready);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bit done;
    done = 1'b0;
    ifc.s_axis_tdata  = w;
    ifc.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = ifc.s_axis_tready;
      @(posedge clk);
      #1;
    end
    ifc.s_axis_tvalid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(ifc.m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(ifc.m_axis_tlast), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_tready", 32'(ifc.s_axis_tready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", 32'(ifc.s_axis_tready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    ifc.s_axis_tdata   = '0;
    ifc.s_axis_tvalid  = 1'b0;
    ifc.m_axis_tready  = 1'b1;
    ifc1.s_axis_tdata  = '0;
    ifc1.s_axis_tvalid = 1'b1;
    ifc1.m_axis_tready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Single word.
    do_reset();
    base = obs_d.size();
    send_word(32'hDDCCBBAA);
    tick(6);
    chk("single_count", 32'(obs_d.size() - base), 32'd4);
    if (obs_d.size() - base >= 4) begin
      chk("single_b0", 32'(obs_d[base]), 32'hAA);
      chk("single_b1", 32'(obs_d[base+1]), 32'hBB);
      chk("single_b2", 32'(obs_d[base+2]), 32'hCC);
      chk("single_b3", 32'(obs_d[base+3]), 32'hDD);
      chk("single_last", 32'({obs_l[base+3], obs_l[base+2], obs_l[base+1], obs_l[base]}), 32'b1000);
      chk("single_span", 32'(obs_c[base+3] - obs_c[base]), 32'd3);
    end
    chk("single_wc", 32'(word_count), 32'd1);

    // Back-to-back words.
    do_reset();
    base = obs_d.size();
    send_word(32'h04030201);
    send_word(32'h08070605);
    tick(8);
    chk("b2b_count", 32'(obs_d.size() - base), 32'd8);
    if (obs_d.size() - base >= 8) begin
      for (int i = 0; i < 8; i++) chk("b2b_data", 32'(obs_d[base+i]), 32'(i + 1));
      chk("b2b_span", 32'(obs_c[base+7] - obs_c[base]), 32'd7);
      chk("b2b_srdy_b04", 32'(obs_s[base+3]), 32'd1);
      chk("b2b_srdy_b03", 32'(obs_s[base+2]), 32'd0);
    end
    chk("b2b_wc", 32'(word_count), 32'd2);

    // Backpressure while BB is presented.
    do_reset();
    base = obs_d.size();
    send_word(32'hDDCCBBAA);
    tick(1);
    ifc.m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_tdata", 32'(ifc.m_axis_tdata), 32'hBB);
      chk("bp_tvalid", 32'(ifc.m_axis_tvalid), 32'd1);
      chk("bp_srdy", 32'(ifc.s_axis_tready), 32'd0);
      @(posedge clk);
      #1;
    end
    ifc.m_axis_tready = 1'b1;
    tick(4);
    chk("bp_count", 32'(obs_d.size() - base), 32'd4);
    if (obs_d.size() - base >= 4) begin
      chk("bp_b2", 32'(obs_d[base+2]), 32'hCC);
      chk("bp_b3", 32'(obs_d[base+3]), 32'hDD);
      chk("bp_gap", 32'(obs_c[base+1] - obs_c[base]), 32'd4);
    end

    // Reset in the middle of a word.
    do_reset();
    base = obs_d.size();
    send_word(32'hDDCCBBAA);
    tick(2);
    reset = 1'b1;
    #1;
    chk("mid_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
    chk("mid_wc", 32'(word_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(4);
    chk("mid_dropped", 32'(obs_d.size() - base), 32'd2);
    send_word(32'h44332211);
    tick(5);
    chk("mid_count", 32'(obs_d.size() - base), 32'd6);
    if (obs_d.size() - base >= 6) begin
      chk("mid_b0", 32'(obs_d[base+2]), 32'h11);
      chk("mid_b3", 32'(obs_d[base+5]), 32'h44);
    end
    chk("mid_wc_after", 32'(word_count), 32'd1);

    // Randomized traffic; the every-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      ifc.m_axis_tready = ($urandom_range(0, 9) < 7);
      ifc.s_axis_tvalid = ($urandom_range(0, 3) != 0);
      ifc.s_axis_tdata  = $urandom;
      if (i == 1500) reset = 1'b1;
      if (i == 1501) reset = 1'b0;
      tick(1);
    end
    ifc.s_axis_tvalid = 1'b0;
    ifc.m_axis_tready = 1'b1;
    tick(6);

    // Word counter wrap on the single-beat instance (one word per cycle).
    ifc1.s_axis_tdata = 8'h5A;
    rst1 = 1'b0;
    tick(1);
    chk("wrap_start_wc", 32'(word_count1), 32'd0);
    chk("wrap_start_tvalid", 32'(ifc1.m_axis_tvalid), 32'd1);
    chk("wrap_tdata", 32'(ifc1.m_axis_tdata), 32'h5A);
    chk("wrap_tlast", 32'(ifc1.m_axis_tlast), 32'd1);
    tick(65535);
    chk("wrap_ffff", 32'(word_count1), 32'hFFFF);
    tick(1);
    chk("wrap_0000", 32'(word_count1), 32'h0000);
    ifc1.s_axis_tdata = 8'hC3;
    tick(1);
    chk("wrap_0001", 32'(word_count1), 32'h0001);
    chk("wrap_tdata2", 32'(ifc1.m_axis_tdata), 32'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
